mem_ctrl: RTL and testbench

//   Memory controller: the responder side of the LSB load/store request interface, plus the

---
 rtl/mem_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder for LSB load/store requests and the instruction-fetch
// port. Word, half and byte requests are turned into byte-serial accesses on
// the 8-bit RAM/IO bus (RAM read data arrives one cycle after mem_a).
//
// Ports
//   clk_in, rst_n_in           clock, asynchronous active-low reset
//   rdy_in                     global ready; 0 freezes the controller
//   clear_all                  flush: aborts loads/fetches, never stores
//   go_work/l_or_s/width/      LSB request (held until received)
//   address/value_store
//   received, has_result,      LSB handshake pulses and zero-extended load data
//   value_load
//   if_req/if_pc               fetch request (pc held until if_done)
//   if_done/if_inst            fetch completion pulse and word
//   mem_din/mem_dout/mem_a/    RAM/IO bus
//   mem_wr
//   io_buffer_full             IO write back-pressure
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting; LSB request has priority over fetch
// ST_LOAD  | byte-serial read for the LSB, cnt_q = cycles since accept
// ST_STORE | byte-serial write, cnt_q = index of byte on the bus
// ST_FETCH | byte-serial 4-byte read for the fetch port
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear_all,
  input  logic        go_work,
  input  logic        l_or_s,
  input  logic [2:0]  width,
  input  logic [31:0] address,
  input  logic [31:0] value_store,
  output logic        received,
  output logic        has_result,
  output logic [31:0] value_load,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_FETCH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        replay_q, replay_d;
  logic        received_q, received_d;
  logic        has_result_q, has_result_d;
  logic [31:0] value_load_q, value_load_d;
  logic        if_done_q, if_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;

  logic [31:0] cnt_ext;
  logic [31:0] st_cur_a;
  logic [31:0] st_next_a;
  logic [1:0]  st_next_idx;
  logic [31:0] wshift;
  logic [1:0]  cap_idx;
  logic [31:0] cap_word;

  function automatic logic [2:0] width_to_bytes(input logic [2:0] w);
    case (w)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cnt_ext     = {29'd0, cnt_q};
  assign st_cur_a    = addr_q + cnt_ext;
  assign st_next_a   = addr_q + cnt_ext + 32'd1;
  assign st_next_idx = cnt_q[1:0] + 2'd1;
  assign wshift      = wdata_q >> {st_next_idx, 3'b000};
  // In a read, the byte on mem_din during cycle cnt_q belongs to index cnt_q-2.
  assign cap_idx     = cnt_q[1:0] - 2'd2;
  assign cap_word    = {24'd0, mem_din} << {cap_idx, 3'b000};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nbytes_d     = nbytes_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    replay_d     = replay_q;
    received_d   = 1'b0;
    has_result_d = 1'b0;
    if_done_d    = 1'b0;
    value_load_d = value_load_q;
    if_inst_d    = if_inst_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;

    if (!rdy_in) begin
      // The bus is not ours while paused, so the read in flight is lost.
      // Park mem_a on the byte that was about to be captured; the first ready
      // cycle re-presents it and the schedule then resumes where it stopped.
      if (state_q == ST_LOAD || state_q == ST_FETCH) begin
        replay_d = 1'b1;
        mem_a_d  = (cnt_q >= 3'd2) ? addr_q + cnt_ext - 32'd2 : 32'd0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!clear_all) begin
            if (go_work) begin
              addr_d     = address;
              nbytes_d   = width_to_bytes(width);
              wdata_d    = value_store;
              received_d = 1'b1;
              mem_a_d    = address;
              if (l_or_s) begin
                state_d    = ST_STORE;
                cnt_d      = 3'd0;
                mem_dout_d = value_store[7:0];
                mem_wr_d   = !(address >= IO_BASE && io_buffer_full);
              end else begin
                state_d = ST_LOAD;
                cnt_d   = 3'd1;
                rdata_d = 32'd0;
              end
            end else if (if_req) begin
              state_d  = ST_FETCH;
              addr_d   = if_pc;
              nbytes_d = 3'd4;
              cnt_d    = 3'd1;
              rdata_d  = 32'd0;
              mem_a_d  = if_pc;
            end
          end
        end

        ST_LOAD, ST_FETCH: begin
          if (clear_all) begin
            state_d  = ST_IDLE;
            replay_d = 1'b0;
            mem_a_d  = 32'd0;
          end else if (replay_q) begin
            replay_d = 1'b0;
            mem_a_d  = (cnt_q <= nbytes_q) ? addr_q + cnt_ext - 32'd1 : 32'd0;
          end else begin
            if (cnt_q >= 3'd2) begin
              rdata_d = rdata_q | cap_word;
            end
            if (cnt_q == nbytes_q + 3'd1) begin
              state_d = ST_IDLE;
              mem_a_d = 32'd0;
              if (state_q == ST_LOAD) begin
                has_result_d = 1'b1;
                value_load_d = rdata_d;
              end else begin
                if_done_d = 1'b1;
                if_inst_d = rdata_d;
              end
            end else begin
              cnt_d   = cnt_q + 3'd1;
              mem_a_d = (cnt_q < nbytes_q) ? addr_q + cnt_ext : 32'd0;
            end
          end
        end

        ST_STORE: begin
          // Stores are committed: clear_all is deliberately ignored here.
          if (mem_wr_q) begin
            if (cnt_q + 3'd1 == nbytes_q) begin
              state_d    = ST_IDLE;
              mem_wr_d   = 1'b0;
              mem_a_d    = 32'd0;
              mem_dout_d = 8'd0;
            end else begin
              cnt_d      = cnt_q + 3'd1;
              mem_a_d    = st_next_a;
              mem_dout_d = wshift[7:0];
              mem_wr_d   = !(st_next_a >= IO_BASE && io_buffer_full);
            end
          end else begin
            mem_wr_d = !(st_cur_a >= IO_BASE && io_buffer_full);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      nbytes_q     <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      rdata_q      <= 32'd0;
      replay_q     <= 1'b0;
      received_q   <= 1'b0;
      has_result_q <= 1'b0;
      value_load_q <= 32'd0;
      if_done_q    <= 1'b0;
      if_inst_q    <= 32'd0;
      mem_a_q      <= 32'd0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nbytes_q     <= nbytes_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      replay_q     <= replay_d;
      received_q   <= received_d;
      has_result_q <= has_result_d;
      value_load_q <= value_load_d;
      if_done_q    <= if_done_d;
      if_inst_q    <= if_inst_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  assign received   = received_q;
  assign has_result = has_result_q;
  assign value_load = value_load_q;
  assign if_done    = if_done_q;
  assign if_inst    = if_inst_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  // A held write byte must not land while paused; it is written on resume.
  assign mem_wr     = mem_wr_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rdy_in;
  logic        clear_all;
  logic        go_work;
  logic        l_or_s;
  logic [2:0]  width;
  logic [31:0] address;
  logic [31:0] value_store;
  logic        received;
  logic        has_result;
  logic [31:0] value_load;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_done;
  logic [31:0] if_inst;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ram [0:65535];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  int          rcv_n, res_n, res_at, ifd_n, ifd_at, wr_hi;
  logic [31:0] res_v, ifd_v;

  mem_ctrl dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .rdy_in         (rdy_in),
    .clear_all      (clear_all),
    .go_work        (go_work),
    .l_or_s         (l_or_s),
    .width          (width),
    .address        (address),
    .value_store    (value_store),
    .received       (received),
    .has_result     (has_result),
    .value_load     (value_load),
    .if_req         (if_req),
    .if_pc          (if_pc),
    .if_done        (if_done),
    .if_inst        (if_inst),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 1-cycle read latency; garbage on the bus while paused.
  always @(posedge clk) begin
    if (mem_wr) begin
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
    mem_din <= rdy_in ? ram[mem_a[15:0]] : 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues one load at the current negedge (cycle c0) and watches 14 cycles.
  task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] w,
                          input logic [31:0] exp_v, input int exp_lat,
                          input int pause_at, input int pause_len);
    int nb;
    nb = (w == 3'd1) ? 1 : (w == 3'd2) ? 2 : 4;
    go_work = 1'b1; l_or_s = 1'b0; width = w; address = a;
    rcv_n = 0; res_n = 0; res_at = -1; res_v = 32'd0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (received) rcv_n++;
      if (k == 1) go_work = 1'b0;
      if (has_result) begin res_n++; res_at = k; res_v = value_load; end
      if (pause_len == 0 && k <= nb) chk({tag, ".mem_a"}, mem_a, a + 32'(k - 1));
      rdy_in = !(k >= pause_at && k < pause_at + pause_len);
    end
    rdy_in = 1'b1;
    chk({tag, ".rcv"}, 32'(rcv_n), 32'd1);
    chk({tag, ".npulse"}, 32'(res_n), 32'd1);
    chk({tag, ".lat"}, 32'(res_at), 32'(exp_lat));
    chk({tag, ".val"}, res_v, exp_v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h78; ram[16'h1001] = 8'h56; ram[16'h1002] = 8'h34; ram[16'h1003] = 8'h12;
    ram[16'h0000] = 8'h93; ram[16'h0001] = 8'h00; ram[16'h0002] = 8'h10; ram[16'h0003] = 8'h00;
    ram[16'h0020] = 8'hF0;
    ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22;

    rst_n = 1'b0; rdy_in = 1'b1; clear_all = 1'b0; go_work = 1'b0; l_or_s = 1'b0;
    width = 3'd0; address = 32'd0; value_store = 32'd0; if_req = 1'b0; if_pc = 32'd0;
    io_buffer_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.received", received, 1'b0);
    chk("rst.has_result", has_result, 1'b0);
    chk("rst.value_load", value_load, 32'd0);
    chk("rst.if_done", if_done, 1'b0);
    chk("rst.if_inst", if_inst, 32'd0);
    chk("rst.mem_a", mem_a, 32'd0);
    chk("rst.mem_dout", mem_dout, 8'd0);
    chk("rst.mem_wr", mem_wr, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a word store
    wlog_a.delete(); wlog_d.delete();
    go_work = 1'b1; l_or_s = 1'b1; width = 3'd4; address = 32'h2000; value_store = 32'hCAFE_BABE;
    @(negedge clk);
    chk("sw.rcv", received, 1'b1);
    chk("sw.wr0", mem_wr, 1'b1);
    chk("sw.a0", mem_a, 32'h2000);
    chk("sw.d0", mem_dout, 8'hBE);
    go_work = 1'b0;
    @(negedge clk);
    chk("sw.wr1", mem_wr, 1'b1);
    chk("sw.a1", mem_a, 32'h2001);
    chk("sw.d1", mem_dout, 8'hBA);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.mem_wr", mem_wr, 1'b0);
    chk("midrst.mem_a", mem_a, 32'd0);
    chk("midrst.mem_dout", mem_dout, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.idle_wr", mem_wr, 1'b0);
    chk("midrst.nwrites", 32'(wlog_a.size()), 32'd2);

    // Loads: word, byte, half, odd width, address wrap, pause mid-word
    run_load("lw",    32'h0000_1000, 3'd4, 32'h1234_5678, 6, 0, 0);
    run_load("lb",    32'h0000_1002, 3'd1, 32'h0000_0034, 3, 0, 0);
    run_load("lh",    32'h0000_1002, 3'd2, 32'h0000_1234, 4, 0, 0);
    run_load("w3",    32'h0000_1000, 3'd3, 32'h1234_5678, 6, 0, 0);
    run_load("wrap",  32'hFFFF_FFFE, 3'd4, 32'h0093_2211, 6, 0, 0);
    run_load("pause", 32'h0000_1000, 3'd4, 32'h1234_5678, 9, 3, 2);

    // Byte store to IO while the buffer is full for 3 cycles
    wlog_a.delete(); wlog_d.delete();
    go_work = 1'b1; l_or_s = 1'b1; width = 3'd1; address = 32'h0003_0000; value_store = 32'h41;
    io_buffer_full = 1'b1;
    res_n = 0; wr_hi = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) go_work = 1'b0;
      if (k <= 3 && mem_wr) wr_hi++;
      if (k == 3) io_buffer_full = 1'b0;
      if (has_result) res_n++;
    end
    chk("io.wr_while_full", 32'(wr_hi), 32'd0);
    chk("io.nwrites", 32'(wlog_a.size()), 32'd1);
    if (wlog_a.size() > 0) begin
      chk("io.addr", wlog_a[0], 32'h0003_0000);
      chk("io.data", {24'd0, wlog_d[0]}, 32'h41);
    end
    chk("io.no_result", 32'(res_n), 32'd0);

    // LSB and fetch requesting together: LSB first, then fetch
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd1; address = 32'h20;
    if_req = 1'b1; if_pc = 32'h0;
    rcv_n = 0; res_n = 0; res_at = -1; res_v = 0; ifd_n = 0; ifd_at = -1; ifd_v = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (received) rcv_n++;
      if (k == 1) go_work = 1'b0;
      if (has_result) begin res_n++; res_at = k; res_v = value_load; end
      if (if_done) begin ifd_n++; ifd_at = k; ifd_v = if_inst; if_req = 1'b0; end
    end
    if_req = 1'b0;
    chk("prio.rcv", 32'(rcv_n), 32'd1);
    chk("prio.res_n", 32'(res_n), 32'd1);
    chk("prio.res_at", 32'(res_at), 32'd3);
    chk("prio.res_v", res_v, 32'h0000_00F0);
    chk("prio.ifd_n", 32'(ifd_n), 32'd1);
    chk("prio.ifd_at", 32'(ifd_at), 32'd9);
    chk("prio.ifd_v", ifd_v, 32'h0010_0093);

    // clear_all in c0+2 of a half load, then a byte load right away
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd2; address = 32'h1000;
    rcv_n = 0; res_n = 0; res_at = -1; res_v = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (received) rcv_n++;
      if (has_result) begin res_n++; res_at = k; res_v = value_load; end
      if (k == 1) go_work = 1'b0;
      if (k == 2) clear_all = 1'b1;
      if (k == 3) begin
        clear_all = 1'b0;
        chk("clr.mem_a", mem_a, 32'd0);
        go_work = 1'b1; width = 3'd1; address = 32'h20;
      end
      if (k == 4) begin
        chk("clr.idle_rcv", received, 1'b1);
        go_work = 1'b0;
      end
    end
    chk("clr.rcv_n", 32'(rcv_n), 32'd2);
    chk("clr.res_n", 32'(res_n), 32'd1);
    chk("clr.res_at", 32'(res_at), 32'd6);
    chk("clr.res_v", res_v, 32'h0000_00F0);

    // clear_all during a word store: all four bytes still land
    wlog_a.delete(); wlog_d.delete();
    go_work = 1'b1; l_or_s = 1'b1; width = 3'd4; address = 32'h3000; value_store = 32'hDEAD_BEEF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) go_work = 1'b0;
      if (k == 2) clear_all = 1'b1;
      if (k == 3) clear_all = 1'b0;
      if (k == 6) chk("clrsw.idle_wr", mem_wr, 1'b0);
    end
    chk("clrsw.nwrites", 32'(wlog_a.size()), 32'd4);
    if (wlog_a.size() == 4) begin
      chk("clrsw.d0", {24'd0, wlog_d[0]}, 32'hEF);
      chk("clrsw.d1", {24'd0, wlog_d[1]}, 32'hBE);
      chk("clrsw.d2", {24'd0, wlog_d[2]}, 32'hAD);
      chk("clrsw.d3", {24'd0, wlog_d[3]}, 32'hDE);
      chk("clrsw.a3", wlog_a[3], 32'h3003);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
